// File: rtl/qspi_sram_responder_pkg.sv
// Shared definitions for the QSPI SRAM responder: opcodes, FSM states, field lengths.
package qspi_sram_responder_pkg;

   localparam logic [7:0]  CMD_READ_DEF  = 8'hEB;
   localparam logic [7:0]  CMD_WRITE_DEF = 8'h38;
   localparam int unsigned PAGE_BYTES    = 1024;
   localparam int unsigned CMD_NIBBLES   = 2;
   localparam int unsigned ADDR_NIBBLES  = 6;
   localparam int unsigned CNT_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_e;

endpackage

// File: rtl/qspi_sram_responder_if.sv
// Quad-SPI link between controller (master) and responder (slave), all clk-synchronous.
interface qspi_sram_responder_if;
   logic       sck;
   logic       ce_n;
   logic [3:0] sio_i;
   logic [3:0] sio_o;
   logic       sio_oe;
   logic       busy;

   modport master (output sck, ce_n, sio_i, input sio_o, sio_oe, busy);
   modport slave  (input sck, ce_n, sio_i, output sio_o, sio_oe, busy);
endinterface

// File: rtl/qspi_sram_responder_mem.sv
// Byte-wide single-port RAM, synchronous read (1 clk latency) and write; block-RAM inferable.
module qspi_sram_responder_mem #(
   parameter int unsigned ADR_W = 16
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADR_W-1:0] addr,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata
);

   localparam int unsigned DEPTH = 1 << ADR_W;

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/qspi_sram_responder.sv
// QPI target serving 0xEB reads / 0x38 writes from internal RAM; sck is edge-detected on clk.
// Optional: QSPI_SRAM_RESP_PAGE_WRAP_EN wraps burst addresses within a 1024-byte page.
module qspi_sram_responder
   import qspi_sram_responder_pkg::*;
#(
   parameter int unsigned ADR_W       = 16,
   parameter int unsigned WAIT_CYCLES = 6,
   parameter logic [7:0]  CMD_READ    = CMD_READ_DEF,
   parameter logic [7:0]  CMD_WRITE   = CMD_WRITE_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   qspi_sram_responder_if.slave  bus
);

`ifdef QSPI_SRAM_RESP_PAGE_WRAP_EN
   localparam logic [ADR_W-1:0] WRAP_MASK = ADR_W'(PAGE_BYTES - 1);
`else
   localparam logic [ADR_W-1:0] WRAP_MASK = '1;
`endif

   // Burst increment: only the bits under WRAP_MASK advance, the rest stay fixed.
   function automatic logic [ADR_W-1:0] addr_inc(input logic [ADR_W-1:0] a);
      return (a & ~WRAP_MASK) | ((a + ADR_W'(1)) & WRAP_MASK);
   endfunction

   state_e             state_q, state_d;
   logic               sck_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [19:0]        sh_q, sh_d;
   logic [ADR_W-1:0]   addr_q, addr_d;
   logic               is_rd_q, is_rd_d;
   logic               hi_q, hi_d;
   logic [3:0]         nib_q, nib_d;
   logic [3:0]         lo_q, lo_d;
   logic [7:0]         wbyte_q, wbyte_d;
   logic               wr_pend_q, wr_pend_d;
   logic [3:0]         sio_o_q, sio_o_d;
   logic               sio_oe_q, sio_oe_d;
   logic               busy_q, busy_d;
   logic               rise_c, fall_c;
   logic [23:0]        shift_in_c;
   logic [ADR_W-1:0]   mem_addr_c;
   logic [7:0]         mem_rdata;

   assign rise_c     = bus.sck & ~sck_d;
   assign fall_c     = ~bus.sck & sck_d;
   assign shift_in_c = {sh_q, bus.sio_i};

   // While the low nibble is pending the RAM already fetches the next byte.
   assign mem_addr_c = (state_q == ST_RDATA && !hi_q) ? addr_inc(addr_q) : addr_q;

   assign bus.sio_o  = sio_o_q;
   assign bus.sio_oe = sio_oe_q;
   assign bus.busy   = busy_q;

   qspi_sram_responder_mem #(.ADR_W(ADR_W)) u_mem (
      .clk   (clk),
      .we    (wr_pend_q),
      .addr  (mem_addr_c),
      .wdata (wbyte_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sck_d     <= 1'b0;
         cnt_q     <= '0;
         sh_q      <= '0;
         addr_q    <= '0;
         is_rd_q   <= 1'b0;
         hi_q      <= 1'b1;
         nib_q     <= '0;
         lo_q      <= '0;
         wbyte_q   <= '0;
         wr_pend_q <= 1'b0;
         sio_o_q   <= '0;
         sio_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sck_d     <= bus.sck;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         addr_q    <= addr_d;
         is_rd_q   <= is_rd_d;
         hi_q      <= hi_d;
         nib_q     <= nib_d;
         lo_q      <= lo_d;
         wbyte_q   <= wbyte_d;
         wr_pend_q <= wr_pend_d;
         sio_o_q   <= sio_o_d;
         sio_oe_q  <= sio_oe_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      addr_d    = addr_q;
      is_rd_d   = is_rd_q;
      hi_d      = hi_q;
      nib_d     = nib_q;
      lo_d      = lo_q;
      wbyte_d   = wbyte_q;
      wr_pend_d = 1'b0;
      sio_o_d   = sio_o_q;
      sio_oe_d  = sio_oe_q;

      // A completed byte retires even if ce_n has just risen.
      if (wr_pend_q) addr_d = addr_inc(addr_q);

      if (bus.ce_n) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         hi_d     = 1'b1;
         sio_oe_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_CMD;
               cnt_d   = '0;
               if (rise_c) begin
                  sh_d  = shift_in_c[19:0];
                  cnt_d = CNT_W'(1);
               end
            end
            ST_CMD: begin
               if (rise_c) begin
                  sh_d  = shift_in_c[19:0];
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(CMD_NIBBLES - 1)) begin
                     cnt_d = '0;
                     if (shift_in_c[7:0] == CMD_READ) begin
                        is_rd_d = 1'b1;
                        state_d = ST_ADDR;
                     end else if (shift_in_c[7:0] == CMD_WRITE) begin
                        is_rd_d = 1'b0;
                        state_d = ST_ADDR;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            ST_ADDR: begin
               if (rise_c) begin
                  sh_d  = shift_in_c[19:0];
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
                     cnt_d   = '0;
                     addr_d  = ADR_W'(shift_in_c);
                     hi_d    = 1'b1;
                     state_d = is_rd_q ? ST_DUMMY : ST_WDATA;
                  end
               end
            end
            ST_DUMMY: begin
               if (rise_c) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                     cnt_d   = '0;
                     state_d = ST_RDATA;
                  end
               end
            end
            ST_RDATA: begin
               if (fall_c) begin
                  sio_oe_d = 1'b1;
                  if (hi_q) begin
                     sio_o_d = mem_rdata[7:4];
                     lo_d    = mem_rdata[3:0];
                     hi_d    = 1'b0;
                  end else begin
                     sio_o_d = lo_q;
                     hi_d    = 1'b1;
                     addr_d  = addr_inc(addr_q);
                  end
               end
            end
            ST_WDATA: begin
               if (rise_c) begin
                  if (hi_q) begin
                     nib_d = bus.sio_i;
                     hi_d  = 1'b0;
                  end else begin
                     wbyte_d   = {nib_q, bus.sio_i};
                     wr_pend_d = 1'b1;
                     hi_d      = 1'b1;
                  end
               end
            end
            ST_IGNORE: begin
               state_d = ST_IGNORE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

endmodule

// File: doc/qspi_sram_responder.md
Name: qspi_sram_responder

Overview:
Synthesizable QSPI responder: the target end of the link driven by qspi_if, for FPGA bring-up without external PSRAM. It decodes quad-mode (QPI) read 0xEB and write 0x38 transactions and serves them from an internal byte-wide block RAM. Runs entirely on the system clock. sck is a clk-domain register output of qspi_if and is edge-detected, not used as a clock.

Parameters:
ADR_W, 16, byte-address width of the internal RAM (2**ADR_W bytes); address bits above ADR_W-1 ignored
WAIT_CYCLES, 6, dummy sck cycles between address and first read data
CMD_READ, 8'hEB, quad fast-read opcode
CMD_WRITE, 8'h38, quad write opcode

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sck  input  1  serial clock from controller, synchronous to clk; min high/low phase 1 clk
ce_n  input  1  chip enable, active low
sio_i  input  4  quad data from controller
sio_o  output  4  quad data to controller
sio_oe  output  1  high while responder drives sio_o
busy  output  1  high while ce_n low and state not IDLE (debug/LED)

Behaviour:
- One clock domain: clk, with asynchronous active-low reset rst_n.
- Reset: state IDLE; sio_o=4'h0; sio_oe=0; busy=0; counters and address cleared. RAM contents not cleared.
- Edge detect: sck_d registered; rise = sck & ~sck_d; fall = ~sck & sck_d. All protocol actions occur on the clk cycle where rise/fall is seen.
- All fields are nibble-serial on sio_i[3:0], MSB nibble first, sampled on rise.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE -> CMD when ce_n sampled low.
- CMD: 2 rises collect the opcode.
  - CMD_READ or CMD_WRITE -> ADDR.
  - Any other opcode -> IGNORE.
- ADDR: 6 rises collect the 24-bit address. Then CMD_READ -> DUMMY; CMD_WRITE -> WDATA.
- DUMMY:
  - Counts WAIT_CYCLES rises.
  - RAM read of the start address is issued on entry; data is ready before first output.
  - After the last dummy rise -> RDATA.
- RDATA:
  - On each fall, drive the next nibble: high nibble of the current byte, then low nibble.
  - sio_oe=1 from the first fall onward.
  - When the high nibble is driven, issue a RAM read of address+1 (1-clk RAM latency fits within one sck period).
  - After the low nibble, the byte address increments.
- WDATA:
  - Rise 1 latches the high nibble; rise 2 completes the byte.
  - RAM write occurs the clk after the completing rise; address then increments.
  - An incomplete byte (ce_n rises after the high nibble only) is discarded.
- IGNORE: no output and no RAM access until ce_n goes high.
- Address wrap: increment is modulo 2**ADR_W (see Optional Feature).
- ce_n high in any state:
  - Next clk: state IDLE, sio_oe=0.
  - sio_o holds its last value.
  - No pending write is lost if its completing rise was already seen.
- rst_n asserted mid-transaction: immediate return to reset values. A write already issued to RAM remains.
- Simultaneous ce_n rise and sck edge in the same clk: ce_n wins; the edge is ignored.

Optional Feature:
- Macro: QSPI_SRAM_RESP_PAGE_WRAP_EN.
- Defined: burst address increments wrap within a 1024-byte page (bits [9:0] wrap; upper bits fixed), matching PSRAM linear-burst page behaviour.
- Undefined: linear increment over the whole array, modulo 2**ADR_W.

Decomposition:
- Shared include qspi_defs.vh: opcode constants (CMD_READ/CMD_WRITE defaults), state encodings, page size 1024. qspi_if uses the same opcodes.
- One sub-module: qspi_resp_mem, a 2**ADR_W x 8 single-port RAM with synchronous read (1-clk latency) and synchronous write, inferable as block RAM.

Test Plan:
- Write then read: write 0x38, addr 0x000100, data A5 3C; then read 0xEB, addr 0x000100 -> after 6 dummy cycles sio_o nibbles A,5,3,C; sio_oe rises on the first data fall.
- Bad opcode: opcode 0x9F, then 8 more sck cycles -> sio_oe stays 0; RAM unchanged; next valid read works.
- Aborted write: write 0x38, addr 0x10, one nibble 0x7, then ce_n high -> read 0x10 returns the previous content.
- Wrap, feature off: ADR_W=16, write 4 bytes at 0x00FFFE -> read 0x000000 returns bytes 3-4. Feature on: same write wraps to 0x00FC00.
- Reset mid-read: assert rst_n low during RDATA -> sio_oe=0 and busy=0 immediately; after release, a new read of the same address returns correct data.
- ce_n glitch between transactions (high 1 clk) -> state returns to IDLE; the next command decodes from its first nibble.
